// File: rtl/dmem_bus_adapter.sv
// dmem_bus_adapter: single-outstanding MEM-stage load/store adapter onto a valid/ready data bus.
// Optional WAIT_RESP/DRAIN response timeout is built in when DMEM_BUS_TIMEOUT_EN is defined.
module dmem_bus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  input  logic        req_misaligned_i,
  output logic        req_ready_o,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        resp_misaligned_o,
  output logic        dbus_req_valid_o,
  input  logic        dbus_req_ready_i,
  output logic [31:0] dbus_addr_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_wstrb_o,
  input  logic        dbus_resp_valid_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_err_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_mis_q, resp_mis_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        tmo_hit;

`ifdef DMEM_BUS_TIMEOUT_EN
  localparam int unsigned CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any state change clears the counter, which covers entry to WAIT_RESP and DRAIN.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == WAIT_RESP || state_q == DRAIN) && !dbus_resp_valid_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
  // TIMEOUT_CYCLES only shapes logic when the timeout is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_mis_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_mis_q   <= resp_mis_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_mis_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          addr_d  = req_addr_i[31:2];
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_we_i ? req_wstrb_i : 4'h0;
          if (req_misaligned_i) begin
            resp_valid_d = 1'b1;
            resp_mis_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (flush_i) begin
          state_d = dbus_req_ready_i ? DRAIN : IDLE;
        end else if (dbus_req_ready_i) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A flush coinciding with the response has nothing left to drain.
        if (flush_i) begin
          state_d = dbus_resp_valid_i ? IDLE : DRAIN;
        end else if (dbus_resp_valid_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = dbus_rdata_i;
          resp_err_d   = dbus_err_i;
        end else if (tmo_hit) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (dbus_resp_valid_i || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o       = (state_q == IDLE);
    stall_o           = !resp_valid_q && ((state_q != IDLE) || req_valid_i);
    dbus_req_valid_o  = (state_q == REQ);
    dbus_addr_o       = {addr_q, 2'b00};
    dbus_we_o         = we_q;
    dbus_wdata_o      = wdata_q;
    dbus_wstrb_o      = wstrb_q;
    resp_valid_o      = resp_valid_q;
    resp_rdata_o      = resp_rdata_q;
    resp_err_o        = resp_err_q;
    resp_misaligned_o = resp_mis_q;
  end

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// tb_dmem_bus_adapter: table vectors, hand-written flush/reset/back-to-back/timeout
// sequences and randomized transactions checked against a transaction-level model.
module tb_dmem_bus_adapter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_we_i, req_misaligned_i, flush_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        req_ready_o, stall_o, resp_valid_o, resp_err_o, resp_misaligned_o;
  logic [31:0] resp_rdata_o;
  logic        dbus_req_valid_o, dbus_req_ready_i, dbus_we_o, dbus_resp_valid_i, dbus_err_i;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]  dbus_wstrb_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  dmem_bus_adapter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i), .req_misaligned_i(req_misaligned_i),
    .req_ready_o(req_ready_o), .flush_i(flush_i), .stall_o(stall_o),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .resp_misaligned_o(resp_misaligned_o),
    .dbus_req_valid_o(dbus_req_valid_o), .dbus_req_ready_i(dbus_req_ready_i),
    .dbus_addr_o(dbus_addr_o), .dbus_we_o(dbus_we_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_wstrb_o(dbus_wstrb_o), .dbus_resp_valid_i(dbus_resp_valid_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        mis;
    int          rd;         // cycles ready is held low in REQ
    int          wd;         // extra cycles before the bus response
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    int          exp_lat;    // accept cycle -> resp_valid_o cycle
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_mis;
  } vec_t;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_wstrb_i = '0; req_misaligned_i = 1'b0; flush_i = 1'b0;
    dbus_req_ready_i = 1'b0; dbus_resp_valid_i = 1'b0; dbus_rdata_i = '0; dbus_err_i = 1'b0;
  endtask

  task automatic present(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic mis);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_wstrb_i = wstrb; req_misaligned_i = mis;
  endtask

  // Transaction-level reference: word-aligned address, loads carry no strobes,
  // misaligned ops finish next cycle without touching the bus, others take 3 + waits.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev_rdata);
    vec_t r = v;
    r.exp_addr  = v.addr & 32'hFFFF_FFFC;
    r.exp_wstrb = v.we ? v.wstrb : 4'h0;
    r.exp_lat   = v.mis ? 1 : 3 + v.rd + v.wd;
    r.exp_rdata = v.mis ? prev_rdata : v.bus_rdata;
    r.exp_err   = v.mis ? 1'b0 : v.bus_err;
    r.exp_mis   = v.mis;
    return r;
  endfunction

  // Starts just after a rising edge with the DUT idle; ends just after the edge
  // following the cycle after the completion pulse.
  task automatic run_txn(input string nm, input vec_t v);
    int  cyc;
    int  hs;
    bit  done;
    idle_in();
    present(v.we, v.addr, v.wdata, v.wstrb, v.mis);
    @(negedge clk);
    chk1({nm, "/acc_ready"}, req_ready_o, 1'b1);
    chk1({nm, "/acc_stall"}, stall_o, 1'b1);
    next_cyc();
    req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = $urandom;
    cyc = 1; hs = -1; done = 1'b0;
    while (!done) begin
      dbus_req_ready_i  = (hs < 0) && (cyc >= 1 + v.rd);
      dbus_resp_valid_i = (hs >= 0) && (cyc == hs + 1 + v.wd);
      dbus_rdata_i      = dbus_resp_valid_i ? v.bus_rdata : $urandom;
      dbus_err_i        = dbus_resp_valid_i ? v.bus_err : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (resp_valid_o) begin
        done = 1'b1;
        chk32({nm, "/latency"}, cyc, v.exp_lat);
        chk32({nm, "/rdata"}, resp_rdata_o, v.exp_rdata);
        chk1({nm, "/err"}, resp_err_o, v.exp_err);
        chk1({nm, "/mis"}, resp_misaligned_o, v.exp_mis);
        chk1({nm, "/resp_stall"}, stall_o, 1'b0);
        chk1({nm, "/resp_ready"}, req_ready_o, 1'b1);
        if (!v.mis) chk32({nm, "/hs_cycle"}, hs, 1 + v.rd);
      end else begin
        chk1({nm, "/busy_stall"}, stall_o, 1'b1);
        chk1({nm, "/busy_ready"}, req_ready_o, 1'b0);
        if (v.mis) begin
          chk1({nm, "/no_bus"}, dbus_req_valid_o, 1'b0);
        end else if (dbus_req_valid_o) begin
          chk32({nm, "/dbus_addr"}, dbus_addr_o, v.exp_addr);
          chk1({nm, "/dbus_we"}, dbus_we_o, v.we);
          chk32({nm, "/dbus_wdata"}, dbus_wdata_o, v.wdata);
          chk32({nm, "/dbus_wstrb"}, 32'(dbus_wstrb_o), 32'(v.exp_wstrb));
          if (dbus_req_ready_i) hs = cyc;
        end
        if (cyc >= 40) begin
          done = 1'b1;
          total++; bad++;
          $display("FAIL %s/no_completion: got none expected pulse at cycle %0d", nm, v.exp_lat);
        end
      end
      next_cyc();
      cyc++;
    end
    idle_in();
    @(negedge clk);
    chk1({nm, "/after_valid"}, resp_valid_o, 1'b0);
    chk1({nm, "/after_err"}, resp_err_o, 1'b0);
    chk1({nm, "/after_mis"}, resp_misaligned_o, 1'b0);
    chk32({nm, "/after_hold"}, resp_rdata_o, v.exp_rdata);
    next_cyc();
  endtask

  vec_t tbl[7];

  initial begin
    int   exp_c;
    int   resp_c;
    logic [31:0] exp_rd;
    logic        exp_err;
    vec_t v;

    tbl[0] = '{1'b1, 32'h0000_1002, 32'hBEEF_0000, 4'hC, 1'b0, 0, 0, 32'hDEAD_0001, 1'b0,
               32'h0000_1000, 4'hC, 3, 32'hDEAD_0001, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_2000, 32'h0000_0000, 4'h0, 1'b0, 4, 0, 32'h1234_5678, 1'b0,
               32'h0000_2000, 4'h0, 7, 32'h1234_5678, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_1001, 32'h0000_AB00, 4'h2, 1'b1, 0, 0, 32'h0000_0000, 1'b0,
               32'h0000_1000, 4'h2, 1, 32'h1234_5678, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 4'hF, 1'b0, 0, 2, 32'hA5A5_5A5A, 1'b1,
               32'hFFFF_FFFC, 4'h0, 5, 32'hA5A5_5A5A, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 32'h8000_0004, 32'h0000_3344, 4'h3, 1'b0, 1, 3, 32'h0000_0000, 1'b0,
               32'h8000_0004, 4'h3, 7, 32'h0000_0000, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'h0000_0002, 32'h0000_0000, 4'h0, 1'b1, 2, 2, 32'hFFFF_0000, 1'b1,
               32'h0000_0000, 4'h0, 1, 32'h0000_0000, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 4'hF, 1'b0, 3, 1, 32'h0F0F_0F0F, 1'b1,
               32'h0000_0FFC, 4'hF, 7, 32'h0F0F_0F0F, 1'b1, 1'b0};

    idle_in();
    rst_i = 1'b1;
    next_cyc();
    @(negedge clk);
    chk1("rst/req_ready", req_ready_o, 1'b1);
    chk1("rst/stall", stall_o, 1'b0);
    chk1("rst/dbus_valid", dbus_req_valid_o, 1'b0);
    chk1("rst/resp_valid", resp_valid_o, 1'b0);
    chk1("rst/resp_err", resp_err_o, 1'b0);
    chk1("rst/resp_mis", resp_misaligned_o, 1'b0);
    chk32("rst/resp_rdata", resp_rdata_o, 32'h0);
    chk32("rst/dbus_addr", dbus_addr_o, 32'h0);
    chk32("rst/dbus_wdata", dbus_wdata_o, 32'h0);
    chk32("rst/dbus_wstrb", 32'(dbus_wstrb_o), 32'h0);
    chk1("rst/dbus_we", dbus_we_o, 1'b0);
    next_cyc();
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), tbl[i]);
    last_rdata = 32'h0F0F_0F0F;

    // flush in WAIT_RESP: erroring response is swallowed, then a normal load
    present(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1'b0);
    next_cyc();
    idle_in(); dbus_req_ready_i = 1'b1;
    @(negedge clk); chk1("fw/hs_valid", dbus_req_valid_o, 1'b1); next_cyc();
    idle_in(); flush_i = 1'b1;
    @(negedge clk); chk1("fw/stall", stall_o, 1'b1); next_cyc();
    idle_in();
    @(negedge clk); chk1("fw/drain_ready", req_ready_o, 1'b0); chk1("fw/drain_resp", resp_valid_o, 1'b0); next_cyc();
    dbus_resp_valid_i = 1'b1; dbus_err_i = 1'b1; dbus_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk); chk1("fw/discard_resp", resp_valid_o, 1'b0); next_cyc();
    idle_in();
    @(negedge clk);
    chk1("fw/idle_resp", resp_valid_o, 1'b0);
    chk1("fw/idle_err", resp_err_o, 1'b0);
    chk1("fw/idle_ready", req_ready_o, 1'b1);
    chk1("fw/idle_stall", stall_o, 1'b0);
    chk32("fw/idle_rdata", resp_rdata_o, last_rdata);
    next_cyc();
    v = '{1'b0, 32'h0000_3004, 32'h0, 4'h0, 1'b0, 0, 0, 32'h5555_AAAA, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0};
    v = model(v, last_rdata);
    run_txn("fw_next", v);
    last_rdata = v.exp_rdata;

    // flush in REQ before the handshake
    present(1'b1, 32'h0000_5000, 32'h1111_1111, 4'hF, 1'b0);
    next_cyc();
    idle_in(); flush_i = 1'b1;
    @(negedge clk); chk1("fr/req_valid", dbus_req_valid_o, 1'b1); next_cyc();
    idle_in();
    @(negedge clk);
    chk1("fr/dropped", dbus_req_valid_o, 1'b0);
    chk1("fr/ready", req_ready_o, 1'b1);
    chk1("fr/no_resp", resp_valid_o, 1'b0);
    chk1("fr/stall", stall_o, 1'b0);
    next_cyc();

    // flush together with the handshake drains the response
    present(1'b0, 32'h0000_5100, 32'h0, 4'h0, 1'b0);
    next_cyc();
    idle_in(); flush_i = 1'b1; dbus_req_ready_i = 1'b1;
    @(negedge clk); next_cyc();
    idle_in();
    @(negedge clk);
    chk1("fh/dropped", dbus_req_valid_o, 1'b0);
    chk1("fh/drain_ready", req_ready_o, 1'b0);
    chk1("fh/drain_stall", stall_o, 1'b1);
    next_cyc();
    dbus_resp_valid_i = 1'b1; dbus_rdata_i = 32'h9999_9999;
    @(negedge clk); chk1("fh/no_resp", resp_valid_o, 1'b0); next_cyc();
    idle_in();
    @(negedge clk); chk1("fh/idle_ready", req_ready_o, 1'b1); chk1("fh/idle_resp", resp_valid_o, 1'b0); next_cyc();

    // reset while in REQ; a stale response afterwards is ignored
    present(1'b1, 32'h0000_6000, 32'hCCCC_DDDD, 4'hF, 1'b0);
    next_cyc();
    idle_in(); rst_i = 1'b1;
    @(negedge clk); chk1("rr/req_valid", dbus_req_valid_o, 1'b1); next_cyc();
    rst_i = 1'b0; dbus_resp_valid_i = 1'b1; dbus_rdata_i = 32'h7777_7777; dbus_err_i = 1'b1;
    @(negedge clk);
    chk1("rr/dropped", dbus_req_valid_o, 1'b0);
    chk1("rr/ready", req_ready_o, 1'b1);
    chk1("rr/resp", resp_valid_o, 1'b0);
    next_cyc();
    idle_in();
    last_rdata = 32'h0;
    @(negedge clk);
    chk1("rr/stale_resp", resp_valid_o, 1'b0);
    chk1("rr/stale_err", resp_err_o, 1'b0);
    chk32("rr/rdata_cleared", resp_rdata_o, last_rdata);
    chk32("rr/addr_cleared", dbus_addr_o, 32'h0);
    next_cyc();

    // back-to-back: second request accepted in the completion cycle of the first
    present(1'b0, 32'h0000_7000, 32'h0, 4'h0, 1'b0);
    next_cyc();
    idle_in(); dbus_req_ready_i = 1'b1;
    @(negedge clk); next_cyc();
    idle_in(); dbus_resp_valid_i = 1'b1; dbus_rdata_i = 32'h1111_2222;
    @(negedge clk); next_cyc();
    idle_in(); present(1'b1, 32'h0000_700B, 32'h5566_7788, 4'h3, 1'b0);
    @(negedge clk);
    chk1("b2b/resp_a", resp_valid_o, 1'b1);
    chk32("b2b/rdata_a", resp_rdata_o, 32'h1111_2222);
    chk1("b2b/stall", stall_o, 1'b0);
    chk1("b2b/ready", req_ready_o, 1'b1);
    next_cyc();
    idle_in(); dbus_req_ready_i = 1'b1;
    @(negedge clk);
    chk1("b2b/req_b", dbus_req_valid_o, 1'b1);
    chk32("b2b/addr_b", dbus_addr_o, 32'h0000_7008);
    chk1("b2b/we_b", dbus_we_o, 1'b1);
    chk32("b2b/wstrb_b", 32'(dbus_wstrb_o), 32'h3);
    chk1("b2b/no_resp", resp_valid_o, 1'b0);
    next_cyc();
    idle_in(); dbus_resp_valid_i = 1'b1; dbus_rdata_i = 32'h0000_0000;
    @(negedge clk); next_cyc();
    idle_in();
    last_rdata = 32'h0;
    @(negedge clk);
    chk1("b2b/resp_b", resp_valid_o, 1'b1);
    chk32("b2b/rdata_b", resp_rdata_o, last_rdata);
    chk1("b2b/err_b", resp_err_o, 1'b0);
    next_cyc();

    // long wait in WAIT_RESP: timeout pulse, or an eventual real response
`ifdef DMEM_BUS_TIMEOUT_EN
    exp_c = 11; resp_c = -1; exp_rd = 32'h0; exp_err = 1'b1;
`else
    exp_c = 21; resp_c = 20; exp_rd = 32'hCAFE_F00D; exp_err = 1'b0;
`endif
    present(1'b0, 32'h0000_4000, 32'h0, 4'h0, 1'b0);
    next_cyc();
    idle_in(); dbus_req_ready_i = 1'b1;
    @(negedge clk); chk1("tmo/hs", dbus_req_valid_o, 1'b1); next_cyc();
    for (int c = 2; c <= exp_c; c++) begin
      idle_in();
      dbus_resp_valid_i = (c == resp_c);
      dbus_rdata_i = dbus_resp_valid_i ? exp_rd : $urandom;
      dbus_err_i   = dbus_resp_valid_i ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk1($sformatf("tmo/pulse_c%0d", c), resp_valid_o, 1'(c == exp_c));
      if (c == exp_c) begin
        chk32("tmo/rdata", resp_rdata_o, exp_rd);
        chk1("tmo/err", resp_err_o, exp_err);
        chk1("tmo/mis", resp_misaligned_o, 1'b0);
      end
      next_cyc();
    end
    idle_in();
    last_rdata = exp_rd;
    @(negedge clk); chk1("tmo/idle_ready", req_ready_o, 1'b1); next_cyc();

    for (int i = 0; i < 60; i++) begin
      v.we        = 1'($urandom_range(0, 1));
      v.addr      = $urandom;
      v.wdata     = $urandom;
      v.wstrb     = 4'($urandom_range(0, 15));
      v.mis       = ($urandom_range(0, 4) == 0);
      v.rd        = int'($urandom_range(0, 3));
      v.wd        = int'($urandom_range(0, 3));
      v.bus_rdata = $urandom;
      v.bus_err   = ($urandom_range(0, 5) == 0);
      v = model(v, last_rdata);
      run_txn($sformatf("rnd%0d", i), v);
      last_rdata = v.exp_rdata;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/dmem_bus_adapter.md
Name: dmem_bus_adapter

Overview:
- Sits directly downstream of the store unit in the MEM stage.
- Takes one load or store request per transaction: address, byte-lane-aligned write data, write strobes and the misaligned flag.
- Runs it as a single outstanding transaction on the valid/ready data bus, then returns read data or an error to the pipeline.
- Holds a stall to the pipeline while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait in WAIT_RESP before forcing a bus error (used only with the optional feature).

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous, active-high reset
- req_valid_i  input  1  MEM stage presents a memory op
- req_we_i  input  1  1 = store, 0 = load
- req_addr_i  input  32  byte address (ALU result)
- req_wdata_i  input  32  lane-shifted store data
- req_wstrb_i  input  4  byte strobes (ignored for loads)
- req_misaligned_i  input  1  misaligned flag from the store/load unit
- req_ready_o  output  1  request accepted this cycle
- flush_i  input  1  squash the in-flight op (trap/redirect)
- stall_o  output  1  pipeline hold
- resp_valid_o  output  1  one-cycle completion pulse
- resp_rdata_o  output  32  raw word read data
- resp_err_o  output  1  bus error or timeout
- resp_misaligned_o  output  1  completion was a misaligned reject
- dbus_req_valid_o  output  1  bus request valid
- dbus_req_ready_i  input  1  bus accepts request
- dbus_addr_o  output  32  word address {addr[31:2],2'b00}
- dbus_we_o  output  1  write enable
- dbus_wdata_o  output  32  write data
- dbus_wstrb_o  output  4  strobes (4'h0 on loads)
- dbus_resp_valid_i  input  1  bus response
- dbus_rdata_i  input  32  bus read data
- dbus_err_i  input  1  bus error, qualified by dbus_resp_valid_i

Behaviour:
- Reset: rst_i sampled on clk_i rising edge.
  - State goes to IDLE.
  - All outputs 0, except req_ready_o = 1 in IDLE.
  - Reset mid-transaction abandons the op; dbus_req_valid_o drops the next cycle.
  - A late dbus_resp_valid_i arriving after reset is ignored.
- States: IDLE, REQ, WAIT_RESP, DRAIN.
- IDLE:
  - req_ready_o = 1 and stall_o = req_valid_i.
  - Accept when req_valid_i is high and flush_i is low; latch addr, we, wdata and wstrb (wstrb forced to 0 for loads).
  - If req_misaligned_i is high: no bus transaction. Next cycle resp_valid_o = 1, resp_misaligned_o = 1, resp_err_o = 0, and state stays IDLE.
  - Otherwise go to REQ.
- REQ:
  - dbus_req_valid_o = 1; all dbus_* fields are held stable until dbus_req_ready_i.
  - On handshake go to WAIT_RESP.
  - flush_i before the handshake: drop dbus_req_valid_o next cycle, go to IDLE, no resp.
  - flush_i in the same cycle as the handshake: go to DRAIN.
- WAIT_RESP:
  - On dbus_resp_valid_i, register dbus_rdata_i and dbus_err_i. Next cycle pulse resp_valid_o with those values, return to IDLE, stall_o = 0.
  - flush_i: go to DRAIN.
- DRAIN:
  - Wait for dbus_resp_valid_i, discard it, return to IDLE.
  - resp_valid_o is never raised.
- stall_o:
  - High in REQ, WAIT_RESP and DRAIN.
  - High in IDLE while an unaccepted req_valid_i is present.
  - Low in the cycle resp_valid_o pulses.
- Response timing: the bus never returns a response in the same cycle as the request handshake. The earliest response is one cycle after it.
- Zero-wait load latency: accept at cycle 0, dbus_req_valid_o at cycle 1 (ready at 1), bus response at 2, resp_valid_o at 3.
- Back-to-back: a new request may be accepted in the same cycle resp_valid_o pulses, since state is IDLE then.
- Outstanding limit: one transaction. req_ready_o = 0 outside IDLE.
- resp_rdata_o holds its last value between pulses; resp_err_o and resp_misaligned_o are 0 when no pulse.

Optional Feature:
- Macro: DMEM_BUS_TIMEOUT_EN.
- When defined:
  - An 8-bit or wider counter sized by $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_RESP or DRAIN and increments each cycle without a response.
  - On reaching TIMEOUT_CYCLES in WAIT_RESP: next cycle resp_valid_o = 1, resp_err_o = 1, resp_rdata_o = 0, and state goes to IDLE.
  - On reaching TIMEOUT_CYCLES in DRAIN: return silently to IDLE.
- When not defined: no counter; WAIT_RESP and DRAIN wait indefinitely.

Test Plan:
- Store, addr 0x1002, wdata 0xBEEF0000, wstrb 4'hC, ready=1, resp at next cycle -> dbus_addr_o=0x1000, dbus_wstrb_o=4'hC, resp_valid_o at cycle 3, resp_err_o=0.
- Load, addr 0x2000, ready held low 4 cycles -> dbus fields stable all 4 cycles, stall_o high throughout, resp_rdata_o=0x12345678 after response.
- Misaligned store, addr 0x1001 -> dbus_req_valid_o never asserts, resp_valid_o=1 and resp_misaligned_o=1 one cycle later.
- flush_i in WAIT_RESP, then response with dbus_err_i=1 -> no resp_valid_o, state IDLE, next load completes normally.
- rst_i in REQ -> dbus_req_valid_o=0 next cycle, req_ready_o=1, stale response ignored.
- With DMEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response -> resp_valid_o with resp_err_o=1 exactly 9 cycles after entering WAIT_RESP.
